// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters (0 = EX-stage issue,
//   1 = auxiliary compare/address unit) with round-robin arbitration. The
//   granted operands drive the ALU. The ALU result is captured in a single
//   response register and returned to the requester that was granted.
//
// Ports
//   clk, rstn                 clock (rising edge), async active-low reset
//   reqN_valid/ready          request handshake for requester N
//   reqN_a/b/op               requester N operands and opcode
//   alu_a/alu_b/alu_op        drive to the shared ALU (NOP_OP and zeros when idle)
//   alu_c                     ALU result, combinational from alu_a/alu_b/alu_op
//   rspN_valid/ready          response handshake for requester N
//   rsp_data                  held result, shared by both response channels
module alu_share_arbiter #(
  parameter int          WIDTH  = 32,
  parameter int          OPW    = 5,
  parameter int unsigned NOP_OP = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data
);

  localparam logic [OPW-1:0] NOP = OPW'(NOP_OP);

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic             owner, last_grant;
  logic [WIDTH-1:0] rsp_q;

  req_t [1:0]       req;
  logic [1:0]       req_vld;
  logic             owner_ready, can_accept;
  logic             gnt_vld, gnt_id;

  assign req[0]  = '{op: req0_op, a: req0_a, b: req0_b};
  assign req[1]  = '{op: req1_op, a: req1_a, b: req1_b};
  assign req_vld = {req1_valid, req0_valid};

  // Only the owner's rsp_ready can free the register; the other is ignored.
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;
  assign can_accept  = (state == EMPTY) || ((state == FULL) && owner_ready);

  // On a tie the requester that did not win last time goes; a lone valid
  // requester always wins.
  assign gnt_vld = can_accept && (|req_vld);
  assign gnt_id  = (&req_vld) ? ~last_grant : req_vld[1];

  assign req0_ready = gnt_vld && !gnt_id;
  assign req1_ready = gnt_vld &&  gnt_id;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = NOP;
    if (gnt_vld) begin
      alu_a  = req[gnt_id].a;
      alu_b  = req[gnt_id].b;
      alu_op = req[gnt_id].op;
    end
  end

  // Drain and a new accept can share an edge, so FULL->FULL is the
  // back-to-back case.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (gnt_vld) state_nxt = FULL;
      FULL:    if (owner_ready) state_nxt = gnt_vld ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_nxt;
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_q      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (gnt_vld) begin
      rsp_q      <= alu_c;
      owner      <= gnt_id;
      last_grant <= gnt_id;
    end
  end

  assign rsp0_valid = (state == FULL) && !owner;
  assign rsp1_valid = (state == FULL) &&  owner;
  assign rsp_data   = rsp_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 5;
  localparam logic [OPW-1:0] OP_NOP = 5'd0;
  localparam logic [OPW-1:0] OP_ADD = 5'd1;
  localparam logic [OPW-1:0] OP_SUB = 5'd2;
  localparam logic [OPW-1:0] OP_AND = 5'd3;
  localparam logic [OPW-1:0] OP_XOR = 5'd4;

  logic             clk, rstn;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c, rsp_data;
  logic [OPW-1:0]   alu_op;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .NOP_OP(0)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data)
  );

  // Shared ALU stand-in
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_c = alu_a + alu_b;
      OP_SUB:  alu_c = alu_a - alu_b;
      OP_AND:  alu_c = alu_a & alu_b;
      OP_XOR:  alu_c = alu_a ^ alu_b;
      default: alu_c = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             owner;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response handshake must match the next expected result.
  always @(negedge clk) begin
    if (rstn && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got data %0h with empty scoreboard at %0t", rsp_data, $time);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_owner", 32'(rsp1_valid), 32'(mon_e.owner));
        chk("rsp_data", rsp_data, mon_e.data);
      end
    end
  end

  logic [WIDTH-1:0] v0a[2], v0b[2], v1a[2], v1b[2], e0[2], e1[2];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i0, i1;
    logic g;
    v0a = '{10, 20}; v0b = '{1, 2}; e0 = '{11, 22};   // ADD
    v1a = '{50, 60}; v1b = '{5, 6}; e1 = '{45, 54};   // SUB

    rstn = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = OP_NOP;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = OP_NOP;
    rsp0_ready = 0; rsp1_ready = 0;

    #2;
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    #10 rstn = 1'b1;
    drive_edge();

    // 1: lone req0 5+3
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = OP_ADD;
    rsp0_ready = 1; rsp1_ready = 1;
    q.push_back({1'b0, 32'd8});
    @(negedge clk);
    chk("t1_req0_ready", 32'(req0_ready), 1);
    chk("t1_req1_ready", 32'(req1_ready), 0);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 3);
    chk("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
    drive_edge();
    req0_valid = 0;
    @(negedge clk);
    chk("t1_rsp0_valid", 32'(rsp0_valid), 1);
    chk("t1_rsp1_valid", 32'(rsp1_valid), 0);
    chk("t1_rsp_data", rsp_data, 8);
    drive_edge();

    // 2: both valid every cycle; last grant was 0, so order is 1,0,1,0
    i0 = 0; i1 = 0;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0);
      req0_valid = 1; req0_a = v0a[i0]; req0_b = v0b[i0]; req0_op = OP_ADD;
      req1_valid = 1; req1_a = v1a[i1]; req1_b = v1b[i1]; req1_op = OP_SUB;
      q.push_back({g, g ? e1[i1] : e0[i0]});
      @(negedge clk);
      chk("t2_req0_ready", 32'(req0_ready), 32'(!g));
      chk("t2_req1_ready", 32'(req1_ready), 32'(g));
      drive_edge();
      if (g) i1++; else i0++;
    end
    req0_valid = 0; req1_valid = 0;
    drive_edge();

    // 3: req1 result stalled 3 cycles while req0 waits
    rsp1_ready = 0;
    req1_valid = 1; req1_a = 7; req1_b = 2; req1_op = OP_XOR;
    q.push_back({1'b1, 32'd5});
    @(negedge clk);
    chk("t3_req1_ready", 32'(req1_ready), 1);
    drive_edge();
    req1_valid = 0;
    req0_valid = 1; req0_a = 30; req0_b = 4; req0_op = OP_ADD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_req0_ready", 32'(req0_ready), 0);
      chk("t3_stall_rsp1_valid", 32'(rsp1_valid), 1);
      chk("t3_stall_rsp_data", rsp_data, 5);
      drive_edge();
    end
    rsp1_ready = 1;
    q.push_back({1'b0, 32'd34});
    @(negedge clk);
    chk("t3_release_req0_ready", 32'(req0_ready), 1);
    drive_edge();
    req0_valid = 0;
    @(negedge clk);
    chk("t3_rsp0_valid", 32'(rsp0_valid), 1);
    drive_edge();

    // 4: idle cycles then lone req1
    @(negedge clk);
    chk("t4_alu_op", 32'(alu_op), 32'(OP_NOP));
    chk("t4_alu_a", alu_a, 0);
    chk("t4_alu_b", alu_b, 0);
    chk("t4_rsp0_valid", 32'(rsp0_valid), 0);
    drive_edge();
    @(negedge clk);
    chk("t4_rsp1_valid", 32'(rsp1_valid), 0);
    drive_edge();
    req1_valid = 1; req1_a = 9; req1_b = 6; req1_op = OP_ADD;
    q.push_back({1'b1, 32'd15});
    @(negedge clk);
    chk("t4_req1_ready", 32'(req1_ready), 1);
    chk("t4_alu_a_req1", alu_a, 9);
    drive_edge();
    req1_valid = 0;
    @(negedge clk);
    drive_edge();

    // 6: rsp0_ready does not drain a result owned by req1
    rsp1_ready = 0; rsp0_ready = 1;
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = OP_ADD;
    q.push_back({1'b1, 32'd7});
    @(negedge clk);
    chk("t6_req1_ready", 32'(req1_ready), 1);
    drive_edge();
    req1_valid = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t6_rsp1_valid", 32'(rsp1_valid), 1);
      chk("t6_rsp0_valid", 32'(rsp0_valid), 0);
      chk("t6_rsp_data", rsp_data, 7);
      drive_edge();
    end

    // 5: drain 7 while req0 takes the register and holds it, then reset
    rsp1_ready = 1; rsp0_ready = 0;
    req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = OP_ADD;
    q.push_back({1'b0, 32'd4});
    @(negedge clk);
    chk("t5_req0_ready", 32'(req0_ready), 1);
    drive_edge();
    req0_valid = 0;
    @(negedge clk);
    chk("t5_held_rsp0_valid", 32'(rsp0_valid), 1);
    drive_edge();
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("t5_rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("t5_rst_rsp_data", rsp_data, 0);
    q.delete();   // the held result is discarded by reset
    #2 rstn = 1'b1;
    drive_edge();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = OP_ADD;
    req1_valid = 1; req1_a = 8; req1_b = 3; req1_op = OP_SUB;
    q.push_back({1'b0, 32'd2});
    @(negedge clk);
    chk("t5_tie_req0_ready", 32'(req0_ready), 1);
    chk("t5_tie_req1_ready", 32'(req1_ready), 0);
    drive_edge();
    req0_valid = 0;
    q.push_back({1'b1, 32'd5});
    @(negedge clk);
    chk("t5_req1_ready", 32'(req1_ready), 1);
    drive_edge();
    req1_valid = 0;
    drive_edge();
    drive_edge();
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
